// File: rtl/delay_line_pkg.sv
// Shared constants and helpers for the tapped delay line and its pulse generators.
// Optional tap multiplexer in delay_line_tapped is enabled by DELAY_LINE_TAP_MUX_EN.
package delay_line_pkg;

  // Edge selection values for the pulse generators
  localparam bit EDGE_FALL = 1'b0;
  localparam bit EDGE_RISE = 1'b1;

  // Default timing: 100 MHz clock, 50 ns between taps, 100 ns pulses
  localparam int CYCLE_NS        = 10;
  localparam int DEF_NTAPS       = 11;
  localparam int DEF_TAP_SPACING = 5;
  localparam int DEF_PULSE_LEN   = 10;

  // Shift-register length needed so the last tap lands on the final stage
  function automatic int line_len(input int ntaps, input int spacing);
    return (ntaps - 1) * spacing + 1;
  endfunction

endpackage

// File: rtl/delay_pulse_gen.sv
// One edge-triggered pulse stretcher: detects the selected trigger edge and
// holds the output high for PULSE_LEN cycles, optionally restarting on a new edge.
module delay_pulse_gen
  import delay_line_pkg::*;
#(
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter bit EDGE_RISE = EDGE_FALL,
  parameter bit RETRIG    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic pulse
);

  localparam int CW = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(PULSE_LEN);

  if (PULSE_LEN < 1) begin : g_bad_pulse_len
    $error("delay_pulse_gen: PULSE_LEN must be >= 1");
  end

  logic          prev_reg;
  logic          edge_det;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  // Previous trigger level keeps tracking through reset so release never fakes an edge
  always_ff @(posedge clk) begin
    prev_reg <= trig;
  end

  // Edge detect and width counter next state
  always_comb begin
    edge_det = EDGE_RISE ? (!prev_reg && trig) : (prev_reg && !trig);
    cnt_next = cnt_reg;
    if (edge_det && ((cnt_reg == '0) || RETRIG)) begin
      cnt_next = LOAD_VAL;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  // Width counter register; reset aborts any pulse in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign pulse = (cnt_reg != '0);

endmodule

// File: rtl/delay_line_tapped.sv
// Parametrised tapped delay line plus NPULSE independent pulse generators.
// Define DELAY_LINE_TAP_MUX_EN to add tap_sel / tap_mux_out, a registered tap selector.
module delay_line_tapped
  import delay_line_pkg::*;
#(
  parameter int NTAPS       = DEF_NTAPS,
  parameter int TAP_SPACING = DEF_TAP_SPACING,
  parameter bit INVERT      = 1'b1,
  parameter int NPULSE      = 2,
  parameter int PULSE_LEN   = DEF_PULSE_LEN,
  parameter bit EDGE_RISE   = EDGE_FALL,
  parameter bit RETRIG      = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din,
  output logic [NTAPS-1:0]           tap_out,
  input  logic [NPULSE-1:0]          trig_in,
  output logic [NPULSE-1:0]          pulse_out
`ifdef DELAY_LINE_TAP_MUX_EN
  ,
  input  logic [$clog2(NTAPS)-1:0]   tap_sel,
  output logic                       tap_mux_out
`endif
);

  localparam int LINE_LEN = line_len(NTAPS, TAP_SPACING);

  if (NTAPS < 2 || TAP_SPACING < 1 || NPULSE < 1 || PULSE_LEN < 1) begin : g_bad_params
    $error("delay_line_tapped: need NTAPS>=2, TAP_SPACING>=1, NPULSE>=1, PULSE_LEN>=1");
  end

  logic [LINE_LEN-1:0] sr_reg;

  // Shift register: new (optionally inverted) sample enters at stage 0
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg <= '0;
    end else begin
      sr_reg <= {sr_reg[LINE_LEN-2:0], din ^ INVERT};
    end
  end

  // Taps are plain wires onto every TAP_SPACING-th stage
  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
    assign tap_out[gi] = sr_reg[gi*TAP_SPACING];
  end

  // One independent pulse generator per trigger channel
  for (genvar gi = 0; gi < NPULSE; gi++) begin : g_pulse
    delay_pulse_gen #(
      .PULSE_LEN (PULSE_LEN),
      .EDGE_RISE (EDGE_RISE),
      .RETRIG    (RETRIG)
    ) u_pulse_gen (
      .clk   (clk),
      .rst   (rst),
      .trig  (trig_in[gi]),
      .pulse (pulse_out[gi])
    );
  end

`ifdef DELAY_LINE_TAP_MUX_EN
  // Registered tap selector; out-of-range selections read as 0
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_mux_out <= 1'b0;
    end else if (int'(tap_sel) < NTAPS) begin
      tap_mux_out <= tap_out[tap_sel];
    end else begin
      tap_mux_out <= 1'b0;
    end
  end
`endif

endmodule
